if_id_fetch_stage: RTL and testbench
====================================

Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. Owns the PC, issues one-outstanding requests to instruction memory, and buffers returned words.
- Presents the IF/ID fields (opcode, rs1, rs2, instr, pc) to the hazard detection unit and decode.
- Obeys the PCWrite/IF_ID_Write stall controls and accepts branch/jump redirects, which flush the pipeline.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- FBUF_DEPTH, 2, fetch buffer entries (power of 2, ≥2).
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PCWrite  in  1  1 = PC may advance; 0 = PC frozen (stall).
- IF_ID_Write  in  1  1 = IF/ID register may load; 0 = hold.
- redirect_valid  in  1  branch/jump taken, from EX.
- redirect_pc  in  32  target PC.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response data valid; always accepted.
- imem_rsp_data  in  32  instruction word.
- IF_ID_valid  out  1  IF/ID holds a real instruction.
- IF_ID_instr  out  32  instruction.
- IF_ID_pc  out  32  PC of that instruction.
- IF_ID_opcode  out  6  IF_ID_instr[31:26].
- IF_ID_rs1  out  5  IF_ID_instr[25:21].
- IF_ID_rs2  out  5  IF_ID_instr[20:16].

Behaviour:
- Reset (async, rst_n=0) sets:
  - pc=RESET_PC, FSM=S_ISSUE, buffer empty, epoch=0.
  - IF_ID_valid=0, IF_ID_instr=NOP_INSTR, IF_ID_pc=0.
  - imem_req_valid=0 while rst_n is low.
- FSM states and transitions:
  - S_ISSUE → S_WAIT: imem_req_valid=1 when PCWrite=1 and buffer has free slot counting the in-flight entry; handshake when valid&ready; pc+=4 on the same edge.
  - S_WAIT → S_ISSUE on imem_rsp_valid. The response is written to the buffer tagged with its pc.
  - S_WAIT → S_DRAIN on redirect while a response is outstanding. In S_DRAIN the next response is discarded, then the FSM goes to S_ISSUE.
- Once asserted, imem_req_valid and imem_req_addr stay stable until ready; they are never dropped by a stall.
- IF/ID load: when IF_ID_Write=1 and the buffer is non-empty, pop the head into IF/ID with IF_ID_valid=1.
  - If IF_ID_Write=1 and the buffer is empty: IF_ID_valid=0, IF_ID_instr=NOP_INSTR (bubble).
  - If IF_ID_Write=0: all IF/ID outputs hold.
- Fetch latency: minimum 2 cycles from request handshake to IF_ID_valid (response cycle + IF/ID load).
- Redirect, which has priority over stalls:
  - pc←redirect_pc, buffer flushed, IF_ID_valid←0, IF_ID_instr←NOP_INSTR regardless of IF_ID_Write.
  - A redirect in the same cycle as a request handshake makes that request stale, so the FSM enters S_DRAIN.
- Buffer full: no new request is issued. Push and pop in the same cycle on a full buffer is legal.
- Counter widths: pc wraps modulo 2^32. Buffer pointers are log2(FBUF_DEPTH)+1 bits.
- Stall: PCWrite=0 blocks a new issue. An already-issued request still completes into the buffer.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] (request handshakes), perf_stall_cnt[31:0] (cycles with IF_ID_Write=0 and IF_ID_valid=1) and perf_flush_cnt[31:0] (redirects).
  - All counters are reset to 0 by rst_n and saturate at all-ones.
- Undefined: these ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package (cpu_pkg) holds:
  - FSM state encodings S_ISSUE/S_WAIT/S_DRAIN.
  - OP_RTYPE=6'b000000 and OP_J=6'b000010.
  - Instruction field bit positions.
  - NOP_INSTR default.
- One sub-module: fetch_fifo (parameterised sync FIFO holding {pc,instr}, with push/pop/flush and full/empty).

Test Plan:
- Reset then free-run, memory ready=1 with 1-cycle response → IF_ID_pc sequence 0,4,8,…; first IF_ID_valid=1 in the 3rd cycle after rst_n deasserts.
- Hold IF_ID_Write=0 and PCWrite=0 for 5 cycles with IF_ID_pc=8 → IF/ID holds pc 8; at most FBUF_DEPTH words buffered; after release pc 12 follows with no duplicate or lost instruction.
- redirect_valid=1 with redirect_pc=0x100 while a response is outstanding → stale response dropped; next IF_ID_valid=1 carries pc 0x100; one bubble with IF_ID_instr=NOP_INSTR is visible.
- imem_req_ready=0 for 4 cycles → imem_req_addr stable; pc unchanged until the handshake.
- Assert rst_n=0 mid-S_WAIT → all outputs return to reset values asynchronously; the late response after reset is ignored.
- With FETCH_PERF_CNT_EN defined: 10 fetches, 3 stall cycles, 1 redirect → counters read 10/3/1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage.
//   - Fetch FSM state encodings (S_ISSUE / S_WAIT / S_DRAIN)
//   - Opcode constants and instruction field bit positions
//   - Default NOP instruction word and field-extraction helpers
package cpu_pkg;

  localparam logic [1:0] S_ISSUE = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS1_MSB    = 25;
  localparam int unsigned RS1_LSB    = 21;
  localparam int unsigned RS2_MSB    = 20;
  localparam int unsigned RS2_LSB    = 16;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  function automatic logic [5:0] instr_opcode(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [4:0] instr_rs1(input logic [31:0] instr);
    return instr[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [4:0] instr_rs2(input logic [31:0] instr);
    return instr[RS2_MSB:RS2_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering fetched {pc, instr} entries.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   flush        - empties the FIFO (wins over push/pop)
//   push, push_data - write an entry (accepted when not full, or full with pop)
//   pop, pop_data   - head entry (combinational) and advance request
//   full, empty  - occupancy flags
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer distinguishes full from empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Owns the PC, issues one-outstanding requests to instruction memory,
// buffers returned words and loads them into IF/ID under stall control.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   PCWrite, IF_ID_Write       - stall controls (0 = freeze PC / hold IF/ID)
//   redirect_valid/_pc         - taken branch/jump from EX; flushes the stage
//   imem_req_*                 - fetch request (valid/ready/addr)
//   imem_rsp_*                 - fetch response, always accepted
//   IF_ID_*                    - valid, instr, pc, opcode, rs1, rs2
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters:
//   perf_fetch_cnt (request handshakes), perf_stall_cnt (held valid
//   IF/ID cycles), perf_flush_cnt (redirects).
module if_id_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FBUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        IF_ID_valid,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc,
  output logic [5:0]  IF_ID_opcode,
  output logic [4:0]  IF_ID_rs1,
  output logic [4:0]  IF_ID_rs2
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic        req_hold;
  logic        req_fire;
  logic        rsp_push;
  logic        buf_pop;
  logic        buf_full;
  logic        buf_empty;
  logic [63:0] buf_head;
  logic        redirect_pc_unused;

  // Targets are word aligned; the low bits are dropped.
  assign redirect_pc_unused = |redirect_pc[1:0];

  // With a single outstanding request and no pushes in S_ISSUE, a free
  // slot now stays free until the response lands. req_hold keeps the
  // request up once raised, even if PCWrite drops before the handshake.
  assign imem_req_valid = rst_n && (state == S_ISSUE) &&
                          (req_hold || (PCWrite && !buf_full));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response coinciding with a redirect is already stale.
  assign rsp_push = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign buf_pop  = IF_ID_Write && !buf_empty && !redirect_valid;

  fetch_fifo #(
    .DEPTH (FBUF_DEPTH),
    .WIDTH (64)
  ) u_fbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_push),
    .push_data ({fetch_pc, imem_rsp_data}),
    .pop       (buf_pop),
    .pop_data  (buf_head),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_ISSUE: if (req_fire) state_nxt = redirect_valid ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid)      state_nxt = S_ISSUE;
        else if (redirect_valid) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (imem_rsp_valid) state_nxt = S_ISSUE;
      default: state_nxt = S_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_ISSUE;
      pc       <= {RESET_PC[31:2], 2'b00};
      fetch_pc <= '0;
      req_hold <= 1'b0;
    end else begin
      state <= state_nxt;
      if (req_fire) fetch_pc <= pc;
      if (redirect_valid)  pc <= {redirect_pc[31:2], 2'b00};
      else if (req_fire)   pc <= pc + 32'd4;
      if (redirect_valid || req_fire) req_hold <= 1'b0;
      else if (imem_req_valid)        req_hold <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_valid <= 1'b0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_pc    <= '0;
    end else if (redirect_valid) begin
      IF_ID_valid <= 1'b0;
      IF_ID_instr <= NOP_INSTR;
    end else if (IF_ID_Write) begin
      if (!buf_empty) begin
        IF_ID_valid <= 1'b1;
        IF_ID_pc    <= buf_head[63:32];
        IF_ID_instr <= buf_head[31:0];
      end else begin
        IF_ID_valid <= 1'b0;
        IF_ID_instr <= NOP_INSTR;
      end
    end
  end

  assign IF_ID_opcode = instr_opcode(IF_ID_instr);
  assign IF_ID_rs1    = instr_rs1(IF_ID_instr);
  assign IF_ID_rs2    = instr_rs2(IF_ID_instr);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (req_fire && perf_fetch_cnt != '1) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!IF_ID_Write && IF_ID_valid && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect_valid && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
module tb_if_id_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCWrite = 1'b1;
  logic        IF_ID_Write = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        IF_ID_valid;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc;
  logic [5:0]  IF_ID_opcode;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  int unsigned mem_lat = 1;

  always #5 clk = ~clk;

  if_id_fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .FBUF_DEPTH (2),
    .NOP_INSTR  (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .IF_ID_valid    (IF_ID_valid),
    .IF_ID_instr    (IF_ID_instr),
    .IF_ID_pc       (IF_ID_pc),
    .IF_ID_opcode   (IF_ID_opcode),
    .IF_ID_rs1      (IF_ID_rs1),
    .IF_ID_rs2      (IF_ID_rs2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory model: one outstanding request, response mem_lat cycles later.
  logic        mem_busy = 1'b0;
  int unsigned mem_wait = 0;
  logic [31:0] mem_addr = '0;
  always @(negedge clk) begin
    #2;
    imem_rsp_valid = 1'b0;
    if (mem_busy) begin
      if (mem_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_busy       = 1'b0;
      end else begin
        mem_wait--;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      mem_busy = 1'b1;
      mem_wait = mem_lat - 1;
      mem_addr = imem_req_addr;
    end
  end

  // Monitor: every new IF/ID load is compared against the expected queue.
  always @(posedge clk) begin
    logic        wr_prev;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    wr_prev = IF_ID_Write;
    #1;
    if (rst_n && wr_prev && IF_ID_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_load: got pc %h, required no load", IF_ID_pc);
      end else begin
        exp_pc    = exp_q.pop_front();
        exp_instr = mem_word(exp_pc);
        check("if_id_pc",     IF_ID_pc, exp_pc);
        check("if_id_instr",  IF_ID_instr, exp_instr);
        check("if_id_opcode", {26'd0, IF_ID_opcode}, {26'd0, exp_instr[31:26]});
        check("if_id_rs1",    {27'd0, IF_ID_rs1}, {27'd0, exp_instr[25:21]});
        check("if_id_rs2",    {27'd0, IF_ID_rs2}, {27'd0, exp_instr[20:16]});
      end
    end
  end

  task automatic wait_load(input logic [31:0] pc);
    bit found = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (IF_ID_valid && IF_ID_pc == pc) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_load: got no load of pc %h, required within 60 cycles", pc);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i <= 10; i++) exp_q.push_back(32'(i * 4));

    // Reset values (PCWrite=1 checks the request gating by rst_n).
    repeat (3) @(negedge clk);
    check("rst_valid",     {31'd0, IF_ID_valid}, 32'd0);
    check("rst_instr",     IF_ID_instr, 32'h0);
    check("rst_pc",        IF_ID_pc, 32'h0);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst_n = 1'b1;

    // First valid IF/ID on the third edge after release.
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("first_valid_edge", {31'd0, IF_ID_valid}, (k == 3) ? 32'd1 : 32'd0);
    end

    // Full stall at pc 8.
    wait_load(32'h8);
    PCWrite = 1'b0;
    IF_ID_Write = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_pc",    IF_ID_pc, 32'h8);
      check("stall_valid", {31'd0, IF_ID_valid}, 32'd1);
      check("stall_noreq", {31'd0, imem_req_valid}, 32'd0);
    end
    PCWrite = 1'b1;
    IF_ID_Write = 1'b1;

    // IF/ID stall only: buffer fills and issue stops.
    wait_load(32'h10);
    IF_ID_Write = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("hold_pc", IF_ID_pc, 32'h10);
    end
    check("full_noreq", {31'd0, imem_req_valid}, 32'd0);
    IF_ID_Write = 1'b1;

    // Memory back-pressure: request held stable.
    wait_load(32'h1C);
    imem_req_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_valid", {31'd0, imem_req_valid}, 32'd1);
      check("bp_addr",  imem_req_addr, 32'h24);
    end
    @(negedge clk);
    imem_req_ready = 1'b1;

    // Redirect while a response is outstanding, under IF/ID stall.
    exp_q.push_back(32'h100);
    wait_load(32'h24);
    mem_lat = 3;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    IF_ID_Write    = 1'b0;
    @(negedge clk);
    check("flush_valid", {31'd0, IF_ID_valid}, 32'd0);
    check("flush_instr", IF_ID_instr, 32'h0);
    redirect_valid = 1'b0;
    IF_ID_Write    = 1'b1;
    mem_lat        = 1;

    // Redirect coinciding with a request handshake, buffer non-empty.
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    wait_load(32'h100);
    @(negedge clk);
    check("hs_redirect_req", {31'd0, imem_req_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("hs_redirect_bubble", {31'd0, IF_ID_valid}, 32'd0);

    // Reset during S_WAIT; late response must be ignored.
    wait_load(32'h200);
    mem_lat = 3;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, IF_ID_valid}, 32'd0);
    check("async_rst_instr", IF_ID_instr, 32'h0);
    check("async_rst_pc",    IF_ID_pc, 32'h0);
    check("async_rst_req",   {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk);
    check("in_rst_req", {31'd0, imem_req_valid}, 32'd0);
    PCWrite = 1'b0;
    rst_n   = 1'b1;
    mem_lat = 1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    repeat (2) @(negedge clk);
    PCWrite = 1'b1;

    wait_load(32'h4);
    PCWrite = 1'b0;
    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", perf_fetch_cnt, 32'd3);
    check("perf_stall", perf_stall_cnt, 32'd0);
    check("perf_flush", perf_flush_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
